sram_obi_arbiter: RTL and testbench
===================================

Name: sram_obi_arbiter

Overview:
- Two-master OBI arbiter that shares the single SRAM data port (the sram_d OBI slave of the SRAM macro wrapper) between the CPU data port (master 0) and the boot/DMA loader (master 1).
- Round-robin arbitration on the request phase; an in-order owner FIFO routes each response back to the master that issued it.
- Sits between the core/loader interconnect and the SRAM wrapper. Supports back-to-back single-cycle-latency traffic and any downstream grant/response latency up to MAX_OUTSTANDING in flight.

Parameters:
MAX_OUTSTANDING, 2, depth of the owner FIFO (max accepted-but-unanswered transactions); must be >= 1
ID_W, 1, width of owner ID stored per entry (fixed 1 for two masters; kept for extension)

Ports:
clk_i  input  1  single clock; all state updates on posedge
rst_ni  input  1  synchronous reset, active low
mN_req_i  input  1  master N request (N = 0 CPU data, N = 1 loader)
mN_gnt_o  output  1  master N grant
mN_addr_i  input  32  master N byte address
mN_we_i  input  1  master N write enable
mN_be_i  input  4  master N byte enables
mN_wdata_i  input  32  master N write data
mN_rvalid_o  output  1  master N response valid
mN_rdata_o  output  32  master N read data
s_req_o / s_gnt_i  output / input  1  request/grant to SRAM sram_d port
s_addr_o, s_we_o, s_be_o, s_wdata_o  output  32/1/4/32  muxed request fields to SRAM
s_rvalid_i / s_rdata_i  input  1 / 32  SRAM response
busy_o  output  1  outstanding count != 0
protocol_err_o  output  1  sticky: response received with owner FIFO empty

Behaviour:
- Reset (rst_ni = 0 at posedge):
  - Owner FIFO emptied; count = 0; rr_last = 1 (so master 0 wins the first contention); protocol_err_o = 0.
  - While rst_ni is low, s_req_o, mN_gnt_o and mN_rvalid_o are forced 0, and s_rvalid_i is ignored.
- Issue enable: issue_ok = (count < MAX_OUTSTANDING), evaluated on registered count only. A pop in the same cycle does not free a slot for that cycle.
- Winner selection (combinational):
  - Only one mN_req_i high: that master wins.
  - Both high: winner = master != rr_last.
  - Neither high: no winner.
- Request outputs:
  - s_req_o = winner exists & issue_ok.
  - s_addr_o/we/be/wdata are the winner's fields. With no winner, all are 0.
- Grant: mN_gnt_o = s_req_o & s_gnt_i & (winner == N). Never more than one grant per cycle.
- Accept = s_req_o & s_gnt_i. On accept: push winner ID into the FIFO and set rr_last <= winner. rr_last changes only on accept.
- Losing master keeps its request asserted (OBI rule). The arbitration decision is not held across cycles; it is recomputed every cycle.
- Response routing:
  - On s_rvalid_i with FIFO non-empty: pop the head and assert m<head>_rvalid_o in the same cycle (combinational, zero added latency).
  - mN_rdata_o = s_rdata_i for both masters at all times; only rvalid is qualified.
- Simultaneous push and pop: count unchanged; FIFO pointers both advance.
- s_rvalid_i with count == 0: no rvalid to either master; protocol_err_o <= 1, held until reset.
- FIFO pointers wrap modulo MAX_OUTSTANDING. count ranges 0..MAX_OUTSTANDING, width $clog2(MAX_OUTSTANDING+1).
- busy_o is registered-state derived (count != 0).
- Throughput:
  - With the SRAM wrapper (gnt = req, rvalid one cycle after accept) and MAX_OUTSTANDING = 2: one accept per cycle, sustained.
  - With MAX_OUTSTANDING = 1: at most one accept every 2 cycles.
- Reset mid-operation: in-flight entries are discarded. The integrator holds rst_ni low >= 2 cycles so stale SRAM responses land during reset.

Test Plan:
- Single master: m0 reads 0x8000_0010 for 4 consecutive cycles, SRAM model gnt = req with 1-cycle rvalid -> m0_gnt_o high all 4 cycles; m0_rvalid_o on cycles 2-5 with matching data; m1_rvalid_o never asserted.
- Contention: m0 and m1 both request every cycle from reset -> grants alternate m0, m1, m0, m1; each rvalid goes to the issuer of the access one cycle earlier; s_addr_o alternates between m0_addr_i and m1_addr_i.
- Backpressure: MAX_OUTSTANDING = 2, SRAM model withholds rvalid for 5 cycles, m1 requests continuously -> exactly 2 accepts, then s_req_o = 0 and m1_gnt_o = 0 until the first rvalid; the next accept occurs the cycle after that pop.
- Simultaneous push/pop at count = 1: accept and rvalid in the same cycle -> count stays 1; busy_o stays 1; response routed to the older owner.
- Spurious response: s_rvalid_i pulse with count = 0 -> no mN_rvalid_o; protocol_err_o rises next cycle and stays 1 until rst_ni low for one cycle.
- Reset mid-burst: rst_ni low for 2 cycles with 2 outstanding -> after release busy_o = 0; the first contention grants m0; no rvalid is delivered for pre-reset transactions.

Source files
------------

// File: rtl/sram_obi_arbiter_if.sv
// OBI request/response bundle used on both the master-facing and SRAM-facing
// sides of the arbiter.
interface sram_obi_arbiter_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_obi_arbiter.sv
// Two-master round-robin OBI arbiter in front of the SRAM data port; an
// in-order owner FIFO steers each response back to the master that issued it.
module sram_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_W            = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    sram_obi_arbiter_if.slave  m0,
    sram_obi_arbiter_if.slave  m1,
    sram_obi_arbiter_if.master s,
    output logic busy_o,
    output logic protocol_err_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [ID_W-1:0]  M0_ID    = '0;
    localparam logic [ID_W-1:0]  M1_ID    = ID_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic [ID_W-1:0]  owner_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [ID_W-1:0]  rr_last_reg;
    logic             err_reg;

    logic             have_winner;
    logic [ID_W-1:0]  winner_id;
    logic [ID_W-1:0]  head_id;
    logic             issue_ok;
    logic             push;
    logic             pop;

    always_comb begin
        have_winner = m0.req | m1.req;
        winner_id   = M0_ID;
        if (m0.req && m1.req) begin
            winner_id = (rr_last_reg == M0_ID) ? M1_ID : M0_ID;
        end else if (m1.req) begin
            winner_id = M1_ID;
        end
    end

    // Only the registered count gates issue, so a same-cycle pop never frees a slot.
    assign issue_ok = (count_reg < CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        s.req   = rst_ni & have_winner & issue_ok;
        s.addr  = '0;
        s.we    = 1'b0;
        s.be    = '0;
        s.wdata = '0;
        if (have_winner && winner_id == M1_ID) begin
            s.addr  = m1.addr;
            s.we    = m1.we;
            s.be    = m1.be;
            s.wdata = m1.wdata;
        end else if (have_winner) begin
            s.addr  = m0.addr;
            s.we    = m0.we;
            s.be    = m0.be;
            s.wdata = m0.wdata;
        end
    end

    assign push    = s.req & s.gnt;
    assign pop     = rst_ni & s.rvalid & (count_reg != '0);
    assign head_id = owner_mem[rd_ptr_reg];

    assign m0.gnt    = push & (winner_id == M0_ID);
    assign m1.gnt    = push & (winner_id == M1_ID);
    assign m0.rvalid = pop & (head_id == M0_ID);
    assign m1.rvalid = pop & (head_id == M1_ID);
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;

    assign busy_o         = (count_reg != '0);
    assign protocol_err_o = err_reg;

    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_owner
            always_ff @(posedge clk_i) begin
                if (push && wr_ptr_reg == PTR_W'(gi)) begin
                    owner_mem[gi] <= winner_id;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rr_last_reg <= M1_ID;
            err_reg     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg  <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
                rr_last_reg <= winner_id;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (s.rvalid && count_reg == '0) begin
                err_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_obi_arbiter.sv
// Randomized scoreboard bench for sram_obi_arbiter: a high-level model predicts
// grants and owners, an SRAM model answers in order, a monitor checks responses.
module tb_sram_obi_arbiter;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_obi_arbiter_if m0_bus ();
    sram_obi_arbiter_if m1_bus ();
    sram_obi_arbiter_if s_bus ();
    logic busy, perr;

    sram_obi_arbiter #(.MAX_OUTSTANDING(MAXO), .ID_W(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
        .busy_o(busy), .protocol_err_o(perr)
    );

    logic        req_v [2];
    logic [31:0] addr_v [2];
    logic        we_v [2];
    logic [3:0]  be_v [2];
    logic [31:0] wdata_v [2];
    logic        s_gnt_v, s_rvalid_v;
    logic [31:0] s_rdata_v;

    assign m0_bus.req = req_v[0];   assign m1_bus.req = req_v[1];
    assign m0_bus.addr = addr_v[0]; assign m1_bus.addr = addr_v[1];
    assign m0_bus.we = we_v[0];     assign m1_bus.we = we_v[1];
    assign m0_bus.be = be_v[0];     assign m1_bus.be = be_v[1];
    assign m0_bus.wdata = wdata_v[0]; assign m1_bus.wdata = wdata_v[1];
    assign s_bus.gnt = s_gnt_v;
    assign s_bus.rvalid = s_rvalid_v;
    assign s_bus.rdata = s_rdata_v;

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    int p_req [2];
    int gnt_pct, lat_min, lat_max;
    bit fixed_addr, spur_req;
    int cyc = 0;

    // reference model state
    typedef struct { int owner; logic [31:0] data; } exp_t;
    exp_t exp_q [$];
    int model_cnt, last_win, accepts;
    bit model_err;
    bit g_seen [2];

    // SRAM model state
    typedef struct { logic [31:0] data; int due; } pend_t;
    pend_t pend_q [$];
    int last_due = 0;

    function automatic logic [31:0] resp_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int n = 0; n < 2; n++) begin
            if (!rst_n) begin
                req_v[n] = 1'b0;
            end else if (!(req_v[n] && !g_seen[n])) begin
                req_v[n]   = ($urandom_range(99) < p_req[n]);
                addr_v[n]  = fixed_addr ? 32'h8000_0010 : $urandom();
                we_v[n]    = 1'($urandom_range(1));
                be_v[n]    = 4'($urandom_range(15));
                wdata_v[n] = $urandom();
            end
        end
        s_gnt_v = ($urandom_range(99) < gnt_pct);
        if (spur_req) begin
            s_rvalid_v = 1'b1;
            s_rdata_v  = $urandom();
            spur_req   = 1'b0;
        end else if (!rst_n) begin
            s_rvalid_v = 1'($urandom_range(1));
            s_rdata_v  = $urandom();
            pend_q.delete();
            last_due = 0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            s_rvalid_v = 1'b1;
            s_rdata_v  = pend_q[0].data;
            void'(pend_q.pop_front());
        end else begin
            s_rvalid_v = 1'b0;
            s_rdata_v  = $urandom();
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
            drive_inputs();
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        s_rvalid_v = 1'b0;
    endtask

    // SRAM model: records accepts it sees on the bus and schedules in-order responses.
    always @(negedge clk) begin
        if (rst_n && s_bus.req && s_bus.gnt) begin
            int due;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due < last_due) due = last_due;
            last_due = due;
            pend_q.push_back('{resp_of(s_bus.addr), due});
        end
    end

    // Reference model: predicts request/grant behaviour and pushes expected responses.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_sreq", s_bus.req, 1'b0);
            check("rst_gnt", {m1_bus.gnt, m0_bus.gnt}, 2'b00);
            check("rst_rvalid", {m1_bus.rvalid, m0_bus.rvalid}, 2'b00);
            model_cnt = 0;
            last_win  = 1;
            model_err = 1'b0;
            exp_q.delete();
            g_seen[0] = 1'b0;
            g_seen[1] = 1'b0;
        end else begin
            bit have, exp_sreq, acc, pop;
            int win;
            check("busy", busy, model_cnt != 0);
            check("protocol_err", perr, model_err);
            have = req_v[0] || req_v[1];
            if (req_v[0] && req_v[1]) win = (last_win == 0) ? 1 : 0;
            else win = req_v[1] ? 1 : 0;
            exp_sreq = have && (model_cnt < MAXO);
            check("s_req", s_bus.req, exp_sreq);
            if (exp_sreq)
                check("s_fields", {s_bus.addr, s_bus.we, s_bus.be, s_bus.wdata},
                      {addr_v[win], we_v[win], be_v[win], wdata_v[win]});
            acc = exp_sreq && s_bus.gnt;
            check("grant", {m1_bus.gnt, m0_bus.gnt}, {acc && win == 1, acc && win == 0});
            g_seen[0] = m0_bus.gnt;
            g_seen[1] = m1_bus.gnt;
            if (acc) begin
                exp_q.push_back('{win, resp_of(addr_v[win])});
                last_win = win;
                accepts++;
            end
            pop = s_bus.rvalid && (model_cnt > 0);
            if (s_bus.rvalid && model_cnt == 0) model_err = 1'b1;
            model_cnt = model_cnt + int'(acc) - int'(pop);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT returns a response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_bus.rvalid || m1_bus.rvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid cycle=%0d actual=%b%b required=00",
                             cyc, m1_bus.rvalid, m0_bus.rvalid);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rvalid_owner", {m1_bus.rvalid, m0_bus.rvalid}, (e.owner == 1) ? 2'b10 : 2'b01);
                    check("rdata", (e.owner == 1) ? m1_bus.rdata : m0_bus.rdata, e.data);
                end
            end else if (s_bus.rvalid && exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL missing_rvalid cycle=%0d actual=00 required=response for m%0d",
                         cyc, exp_q[0].owner);
            end
        end
    end

    initial begin
        int a0, budget;
        for (int n = 0; n < 2; n++) begin
            req_v[n] = 1'b0; addr_v[n] = '0; we_v[n] = 1'b0; be_v[n] = '0; wdata_v[n] = '0;
            p_req[n] = 0;
        end
        s_gnt_v = 1'b0; s_rvalid_v = 1'b0; s_rdata_v = '0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; fixed_addr = 1'b0; spur_req = 1'b0;
        accepts = 0;

        rst_n = 1'b0;
        run(3);
        release_reset();

        // single master, back-to-back one-cycle latency
        fixed_addr = 1'b1; p_req[0] = 100;
        run(1); a0 = accepts; run(4);
        check("single_throughput", accepts - a0, 4);
        fixed_addr = 1'b0; p_req[0] = 0;
        run(6);

        // contention: grants alternate and sustain one accept per cycle
        p_req[0] = 100; p_req[1] = 100;
        run(1); a0 = accepts; run(20);
        check("contention_throughput", accepts - a0, 20);
        p_req[0] = 0; p_req[1] = 0;
        run(6);

        // backpressure: slow responses cap acceptance at the FIFO depth
        lat_min = 6; lat_max = 6; p_req[1] = 100;
        run(1); a0 = accepts; run(4);
        check("backpressure_accepts", accepts - a0, MAXO);
        run(16);
        p_req[1] = 0;
        run(12);
        lat_min = 1; lat_max = 1;

        // spurious response with nothing outstanding
        spur_req = 1'b1;
        run(4);
        check("perr_sticky", perr, 1'b1);
        rst_n = 1'b0;
        run(1);
        release_reset();
        run(2);

        // reset in the middle of a contended burst
        lat_min = 3; lat_max = 3; p_req[0] = 100; p_req[1] = 100;
        run(6);
        rst_n = 1'b0;
        run(2);
        release_reset();
        run(10);

        // randomized traffic
        lat_min = 1; lat_max = 4; gnt_pct = 70; p_req[0] = 60; p_req[1] = 60;
        run(1500);

        // drain with a bounded wait
        p_req[0] = 0; p_req[1] = 0; gnt_pct = 100;
        budget = 60;
        while (budget > 0 && (exp_q.size() != 0 || req_v[0] || req_v[1])) begin
            run(1);
            budget--;
        end
        run(2);
        check("drain_empty", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
